// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter widths, lock states and pixel payload type
// for the VGA stream receiver.
package vga_timing_pkg;

    localparam int unsigned H_SYNC_NOM   = 96;
    localparam int unsigned H_BACK_NOM   = 48;
    localparam int unsigned H_ACTIVE_NOM = 640;
    localparam int unsigned H_FRONT_NOM  = 16;
    localparam int unsigned V_SYNC_NOM   = 2;
    localparam int unsigned V_BACK_NOM   = 33;
    localparam int unsigned V_ACTIVE_NOM = 480;
    localparam int unsigned V_FRONT_NOM  = 10;
    localparam int unsigned LOCK_FRAMES_NOM = 2;

    localparam int unsigned H_TOTAL_NOM = H_SYNC_NOM + H_BACK_NOM + H_ACTIVE_NOM + H_FRONT_NOM;
    localparam int unsigned V_TOTAL_NOM = V_SYNC_NOM + V_BACK_NOM + V_ACTIVE_NOM + V_FRONT_NOM;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned GOOD_W  = 4;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Stage-1 capture of syncs and colour, plus falling-edge detection on the captured syncs.
module vga_sync_edge
    import vga_timing_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic hsync,
    input  logic vsync,
    input  rgb_t rgb,
    output rgb_t rgb_s1,
    output logic hfall_c,
    output logic vfall_c
);

    logic hs_s1;
    logic vs_s1;
    logic hs_d;
    logic vs_d;

    // Syncs idle high so a stream already low at reset release still shows a fall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
            hs_d   <= 1'b1;
            vs_d   <= 1'b1;
            rgb_s1 <= '0;
        end else begin
            hs_s1  <= hsync;
            vs_s1  <= vsync;
            hs_d   <= hs_s1;
            vs_d   <= vs_s1;
            rgb_s1 <= rgb;
        end
    end

    assign hfall_c = hs_d & ~hs_s1;
    assign vfall_c = vs_d & ~vs_s1;

endmodule

// File: rtl/vga_stream_receiver.sv
// VGA sink: recovers pixel coordinates, checks line/frame timing, tracks lock and
// emits a registered pixel stream while locked.
module vga_stream_receiver
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC      = H_SYNC_NOM,
    parameter int unsigned H_BACK      = H_BACK_NOM,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_NOM,
    parameter int unsigned H_FRONT     = H_FRONT_NOM,
    parameter int unsigned V_SYNC      = V_SYNC_NOM,
    parameter int unsigned V_BACK      = V_BACK_NOM,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_NOM,
    parameter int unsigned V_FRONT     = V_FRONT_NOM,
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_NOM
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             vga_hsync,
    input  logic             vga_vsync,
    input  logic [PIX_W-1:0] R,
    input  logic [PIX_W-1:0] G,
    input  logic [PIX_W-1:0] B,
    output logic             pix_valid,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic [PIX_W-1:0] pix_R,
    output logic [PIX_W-1:0] pix_G,
    output logic [PIX_W-1:0] pix_B,
    output logic             frame_start,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START   = H_SYNC + H_BACK;
    localparam int unsigned H_END     = H_START + H_ACTIVE;
    localparam int unsigned V_START   = V_SYNC + V_BACK;
    localparam int unsigned V_END     = V_START + V_ACTIVE;
    localparam int unsigned ERR_SUM_W = ERR_W + 1;

    localparam logic [H_CNT_W-1:0] H_MAX = '1;
    localparam logic [V_CNT_W-1:0] V_MAX = '1;

    rgb_t rgb_in;
    rgb_t rgb_s1;
    logic hfall_c;
    logic vfall_c;

    logic [H_CNT_W-1:0] h_prev;
    logic [H_CNT_W-1:0] h_cnt_c;
    logic [V_CNT_W-1:0] v_prev;
    logic [V_CNT_W-1:0] v_cnt_c;
    logic               h_sat_seen;
    logic               line_open;
    logic               frame_dirty;

    logic judged_c;
    logic sat_hit_c;
    logic len_bad_c;
    logic bad_line_c;
    logic bad_frame_c;
    logic active_c;
    logic valid_c;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [GOOD_W-1:0]    good_cnt;
    logic [GOOD_W-1:0]    good_nxt;
    logic [ERR_SUM_W-1:0] err_sum_c;
    logic [ERR_W-1:0]     err_nxt_c;

    assign rgb_in = {R, G, B};

    vga_sync_edge u_sync_edge (
        .clock   (clock),
        .reset   (reset),
        .hsync   (vga_hsync),
        .vsync   (vga_vsync),
        .rgb     (rgb_in),
        .rgb_s1  (rgb_s1),
        .hfall_c (hfall_c),
        .vfall_c (vfall_c)
    );

    // Position of the stage-1 sample: restarts on the sync fall, otherwise counts on
    always_comb begin
        h_cnt_c = h_prev;
        if (hfall_c) begin
            h_cnt_c = '0;
        end else if (h_prev != H_MAX) begin
            h_cnt_c = h_prev + 1'b1;
        end

        v_cnt_c = v_prev;
        if (vfall_c) begin
            v_cnt_c = '0;
        end else if (hfall_c && (v_prev != V_MAX)) begin
            v_cnt_c = v_prev + 1'b1;
        end
    end

    // Nothing is judged until the first vfall; a saturated line is charged once only
    always_comb begin
        judged_c    = (state != ST_HUNT);
        sat_hit_c   = !hfall_c && (h_cnt_c == H_MAX) && !h_sat_seen;
        len_bad_c   = hfall_c && line_open && !h_sat_seen &&
                      (h_prev != H_CNT_W'(H_TOTAL - 1));
        bad_line_c  = judged_c && (sat_hit_c || len_bad_c);
        bad_frame_c = judged_c && vfall_c &&
                      ((v_prev != V_CNT_W'(V_TOTAL - 1)) || frame_dirty || bad_line_c);
        active_c    = (h_cnt_c >= H_CNT_W'(H_START)) && (h_cnt_c < H_CNT_W'(H_END)) &&
                      (v_cnt_c >= V_CNT_W'(V_START)) && (v_cnt_c < V_CNT_W'(V_END));
    end

    always_comb begin
        err_sum_c = ERR_SUM_W'(err_count) + ERR_SUM_W'(bad_line_c) + ERR_SUM_W'(bad_frame_c);
        err_nxt_c = err_sum_c[ERR_W] ? '1 : err_sum_c[ERR_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_prev      <= '0;
            v_prev      <= '0;
            h_sat_seen  <= 1'b0;
            line_open   <= 1'b0;
            frame_dirty <= 1'b0;
            err_count   <= '0;
        end else begin
            h_prev    <= h_cnt_c;
            v_prev    <= v_cnt_c;
            err_count <= err_nxt_c;
            if (hfall_c) begin
                h_sat_seen <= 1'b0;
                line_open  <= 1'b1;
            end else if (sat_hit_c) begin
                h_sat_seen <= 1'b1;
            end
            if (vfall_c) begin
                frame_dirty <= 1'b0;
            end else if (bad_line_c) begin
                frame_dirty <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_HUNT;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        case (state)
            ST_HUNT: begin
                if (vfall_c) begin
                    state_nxt = ST_VERIFY;
                    good_nxt  = '0;
                end
            end
            ST_VERIFY: begin
                if (bad_line_c || bad_frame_c) begin
                    good_nxt = '0;
                end else if (vfall_c) begin
                    if (good_cnt >= GOOD_W'(LOCK_FRAMES - 1)) begin
                        state_nxt = ST_LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_cnt + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (bad_line_c || bad_frame_c) begin
                    state_nxt = ST_VERIFY;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_HUNT;
                good_nxt  = '0;
            end
        endcase
    end

    assign valid_c = (state_nxt == ST_LOCKED) && active_c;

    // Stage 2: pixel payload holds its last value outside valid pixels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_R       <= '0;
            pix_G       <= '0;
            pix_B       <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            locked      <= (state_nxt == ST_LOCKED);
            pix_valid   <= valid_c;
            frame_start <= valid_c && (h_cnt_c == H_CNT_W'(H_START)) &&
                           (v_cnt_c == V_CNT_W'(V_START));
            if (valid_c) begin
                pix_x <= X_W'(h_cnt_c - H_CNT_W'(H_START));
                pix_y <= Y_W'(v_cnt_c - V_CNT_W'(V_START));
                pix_R <= rgb_s1.r;
                pix_G <= rgb_s1.g;
                pix_B <= rgb_s1.b;
            end
        end
    end

endmodule

// File: tb/tb_vga_stream_receiver.sv
// Directed bench for vga_stream_receiver on a scaled-down raster (17x10) with
// hand-derived lock, error and pixel-count expectations.
module tb_vga_stream_receiver;

    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;
    localparam int NPIX = HA * VA;

    logic       clock = 1'b0;
    logic       reset;
    logic       vga_hsync, vga_vsync;
    logic [7:0] R, G, B;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [7:0] pix_R, pix_G, pix_B;
    logic       frame_start;
    logic       locked;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;
    int step_in_frame = 0;
    int n_valid, n_fs, n_bad;
    int rise_frame = -1, rise_step = -1, fall_frame = -1, fall_step = -1;
    logic last_locked = 1'b0;
    logic prev_act = 1'b0;
    int prev_x = 0, prev_y = 0;
    logic [7:0] prev_r = '0, prev_g = '0, prev_b = '0;

    vga_stream_receiver #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .LOCK_FRAMES(2)
    ) u_dut (
        .clock(clock), .reset(reset),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .R(R), .G(G), .B(B),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
        .frame_start(frame_start), .locked(locked), .err_count(err_count)
    );

    always #20 clock = ~clock;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel clock: drive inputs, sample just after the edge, monitor the stream
    task automatic drive_step(input logic hs, input logic vs, input logic act,
                              input int x, input int y);
        vga_hsync = hs;
        vga_vsync = vs;
        R = act ? 8'(x) : 8'hEE;
        G = act ? 8'(y) : 8'h55;
        B = act ? 8'(x + y) : 8'h33;
        @(posedge clock);
        #1;
        if (pix_valid) begin
            n_valid++;
            if (!prev_act || !locked || int'(pix_x) != prev_x || int'(pix_y) != prev_y ||
                pix_R != prev_r || pix_G != prev_g || pix_B != prev_b)
                n_bad++;
        end
        if (frame_start) begin
            n_fs++;
            if (!pix_valid || pix_x != 10'd0 || pix_y != 9'd0) n_bad++;
        end
        if (locked && !last_locked) begin
            rise_frame = frame_no;
            rise_step  = step_in_frame;
        end
        if (!locked && last_locked) begin
            fall_frame = frame_no;
            fall_step  = step_in_frame;
        end
        last_locked = locked;
        prev_act = act;
        prev_x = x;
        prev_y = y;
        prev_r = R;
        prev_g = G;
        prev_b = B;
        step_in_frame++;
    endtask

    task automatic gen_frame(input int lines, input int short_line, input int short_len,
                             input int max_steps);
        int n;
        n = 0;
        frame_no++;
        step_in_frame = 0;
        n_valid = 0;
        n_fs = 0;
        n_bad = 0;
        for (int l = 0; l < lines; l++) begin
            int len;
            len = (l == short_line) ? short_len : HT;
            for (int h = 0; h < len; h++) begin
                if (n == max_steps) return;
                drive_step(h >= HS, l >= VS,
                           (h >= HST) && (h < HST + HA) && (l >= VST) && (l < VST + VA),
                           h - HST, l - VST);
                n++;
            end
        end
    endtask

    task automatic run_frame(input string tag, input int lines, input int short_line,
                             input int short_len, input int exp_valid);
        gen_frame(lines, short_line, short_len, 1 << 30);
        check_val({tag, "_valid"}, n_valid, exp_valid);
        check_val({tag, "_fs"}, n_fs, int'(exp_valid > 0));
        check_val({tag, "_data"}, n_bad, 0);
    endtask

    task automatic idle_steps(input int n, input logic hs);
        frame_no++;
        step_in_frame = 0;
        for (int i = 0; i < n; i++) drive_step(hs, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        R = '0; G = '0; B = '0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_valid", int'(pix_valid), 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_err", int'(err_count), 0);
        check_val("rst_x", int'(pix_x), 0);
        check_val("rst_fs", int'(frame_start), 0);
        @(negedge clock);
        reset = 1'b0;

        // Lock on the third vfall after reset
        run_frame("f1", VT, -1, 0, 0);
        run_frame("f2", VT, -1, 0, 0);
        check_val("lock_pre_f3", int'(locked), 0);
        run_frame("f3", VT, -1, 0, NPIX);
        check_val("rise_frame_f3", rise_frame, 3);
        check_val("rise_step_f3", rise_step, 1);
        check_val("err_f3", int'(err_count), 0);
        check_val("hold_x_f3", int'(pix_x), HA - 1);
        check_val("hold_y_f3", int'(pix_y), VA - 1);
        check_val("hold_r_f3", int'(pix_R), HA - 1);
        check_val("hold_b_f3", int'(pix_B), HA - 1 + VA - 1);

        // Short line while locked: lock drops right after the closing hfall
        run_frame("f4", VT, 5, HT - 1, 2 * HA);
        check_val("fall_frame_f4", fall_frame, 4);
        check_val("fall_step_f4", fall_step, 5 * HT + (HT - 1) + 1);
        check_val("err_f4", int'(err_count), 1);
        check_val("lock_f4", int'(locked), 0);
        run_frame("f5", VT, -1, 0, 0);
        check_val("err_f5", int'(err_count), 2);
        check_val("hold_y_f5", int'(pix_y), 1);
        check_val("hold_b_f5", int'(pix_B), HA - 1 + 1);
        run_frame("f6", VT, -1, 0, 0);
        run_frame("f7", VT, -1, 0, NPIX);
        check_val("rise_frame_f7", rise_frame, 7);
        check_val("rise_step_f7", rise_step, 1);
        check_val("err_f7", int'(err_count), 2);

        // Frame one line short
        run_frame("f8", VT - 1, -1, 0, NPIX);
        check_val("err_f8", int'(err_count), 2);
        run_frame("f9", VT, -1, 0, 0);
        check_val("fall_frame_f9", fall_frame, 9);
        check_val("fall_step_f9", fall_step, 1);
        check_val("err_f9", int'(err_count), 3);
        run_frame("f10", VT, -1, 0, 0);
        run_frame("f11", VT, -1, 0, NPIX);
        check_val("rise_frame_f11", rise_frame, 11);
        check_val("lock_f11", int'(locked), 1);

        // hsync stuck high: h counter saturates, one bad line only
        idle_steps(3000, 1'b1);
        check_val("err_stuck", int'(err_count), 4);
        check_val("lock_stuck", int'(locked), 0);
        check_val("fall_frame_stuck", fall_frame, 12);
        check_val("fall_step_stuck", fall_step, 2048 - HT);
        run_frame("f13", VT, -1, 0, 0);
        check_val("err_f13", int'(err_count), 5);
        run_frame("f14", VT, -1, 0, 0);
        check_val("err_f14", int'(err_count), 5);
        run_frame("f15", VT, -1, 0, NPIX);
        check_val("rise_frame_f15", rise_frame, 15);
        check_val("err_f15", int'(err_count), 5);

        // Reset mid-line while locked
        gen_frame(VT, -1, 0, VST * HT + HST + 3);
        check_val("pre_rst_lock", int'(locked), 1);
        check_val("pre_rst_valid", int'(pix_valid), 1);
        #5;
        reset = 1'b1;
        #1;
        check_val("arst_valid", int'(pix_valid), 0);
        check_val("arst_locked", int'(locked), 0);
        check_val("arst_err", int'(err_count), 0);
        check_val("arst_x", int'(pix_x), 0);
        check_val("arst_r", int'(pix_R), 0);
        check_val("arst_fs", int'(frame_start), 0);
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        last_locked = 1'b0;
        prev_act = 1'b0;
        idle_steps(6, 1'b1);
        run_frame("f18", VT, -1, 0, 0);
        run_frame("f19", VT, -1, 0, 0);
        check_val("lock_pre_f20", int'(locked), 0);
        run_frame("f20", VT, -1, 0, NPIX);
        check_val("rise_frame_f20", rise_frame, 20);
        check_val("rise_step_f20", rise_step, 1);
        check_val("err_f20", int'(err_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
